sram_burst_ctrl: RTL
====================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- WL_ADDR, 8, SRAM address width.
- WL_DATA, 32, SRAM data width.
- WL_LEN, 8, burst length field width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  main clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  WL_ADDR  start word address.
- cmd_len  in  WL_LEN  beats minus one.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accept.
- wr_data  in  WL_DATA  write beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat accept.
- rd_data  out  WL_DATA  read beat data.
- rd_last  out  1  final read beat of burst.
- mem_addr  out  WL_ADDR  SRAM address.
- mem_wdata  out  WL_DATA  SRAM write data.
- mem_ena  out  1  SRAM write enable.
- mem_rdata  in  WL_DATA  SRAM read data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.
REQ-003 The clock SHALL be the single clock; rst SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WR, RD.
REQ-005 A handshake on any channel SHALL occur when valid and ready are both high at a rising clk edge.
REQ-006 cmd_ready SHALL be 1 only in IDLE; on a command handshake the block SHALL latch addr and beat count (cmd_len+1), then enter WR if cmd_write=1, else RD.
REQ-007 In WR, wr_ready SHALL be 1, mem_ena SHALL equal wr_valid (combinational), mem_addr SHALL be the current address, and mem_wdata SHALL equal wr_data.
- The SRAM write commits at the handshake edge, i.e. zero added latency.
REQ-008 Each write or read issue SHALL increment the address modulo 2^WL_ADDR (wrap 0xFF -> 0x00 at default width).
REQ-009 After the last write handshake, the FSM SHALL go to IDLE and assert done for exactly the next cycle.
REQ-010 In RD, mem_ena SHALL be 0, and the block SHALL present successive read addresses on mem_addr.
- SRAM read latency is 1 cycle: data for the address presented in cycle N is captured from mem_rdata in cycle N+1.
REQ-011 Read data SHALL pass through a 2-entry FIFO driving rd_valid, rd_data and rd_last.
- A new read SHALL issue only when (FIFO occupancy + reads in flight) < 2, so no beat is ever dropped under rd_ready=0.
REQ-012 Read beats SHALL be returned in address order; rd_last SHALL be 1 only on beat cmd_len+1.
REQ-013 When the rd_last beat is handshaken, the FSM SHALL go to IDLE and assert done for exactly the next cycle.
REQ-014 With rd_ready held at 1, RD throughput SHALL be 1 beat/cycle, and the first rd_valid SHALL rise 2 cycles after the command handshake.
REQ-015 busy SHALL be 1 in WR and RD and 0 in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-016 cmd_len=0 SHALL produce a single-beat burst with rd_last=1 on that beat.
REQ-017 In a simultaneous FIFO push and pop, occupancy SHALL stay unchanged and data order SHALL be preserved.

Reset
REQ-018 While rst=0, the block SHALL hold the following values:
- FSM in IDLE, FIFO empty, in-flight count 0.
- cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0.
- mem_ena=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
REQ-019 Reset asserted mid-burst SHALL abort the burst immediately, with mem_ena low in the same cycle and no done pulse.
REQ-020 After rst rises, cmd_ready SHALL be 1 at the first rising clk edge.

Verification
REQ-021 Write burst: addr=0x10, len=3, data 0xA0..0xA3 with wr_valid=1 throughout -> mem_ena high 4 cycles, SRAM[0x10..0x13]=0xA0..0xA3, done pulses once.
REQ-022 Read back: addr=0x10, len=3, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, rd_last on 0xA3, first rd_valid 2 cycles after the command.
REQ-023 Backpressure: the same read with rd_ready toggling 1,0,0,1,... -> no lost or duplicated beats, order preserved, mem_addr never more than 2 words ahead of the accepted beat.
REQ-024 Wrap: write addr=0xFE, len=2 -> SRAM[0xFE], [0xFF], [0x00] written.
REQ-025 Reset mid-read after 2 of 4 beats -> rd_valid=0 and busy=0 immediately, cmd_ready=1 after release, next command served normally.
REQ-026 Single beat: read with len=0 -> exactly one beat with rd_last=1, then done pulse.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// Burst controller between a command/beat streaming interface and a
// single-port synchronous SRAM with one cycle of read latency.
// Writes go straight through to the SRAM; reads are buffered in a 2-entry
// FIFO so a stalled consumer never loses a beat.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WR    | streaming write beats into the SRAM
// RD    | issuing reads and returning beats through the FIFO
module sram_burst_ctrl #(
    parameter int WL_ADDR = 8,
    parameter int WL_DATA = 32,
    parameter int WL_LEN  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [WL_ADDR-1:0] cmd_addr,
    input  logic [WL_LEN-1:0]  cmd_len,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [WL_DATA-1:0] wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [WL_DATA-1:0] rd_data,
    output logic               rd_last,
    output logic [WL_ADDR-1:0] mem_addr,
    output logic [WL_DATA-1:0] mem_wdata,
    output logic               mem_ena,
    input  logic [WL_DATA-1:0] mem_rdata,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic [WL_LEN:0] ONE = (WL_LEN+1)'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WL_ADDR-1:0]   r_addr;
    logic [WL_LEN:0]      r_remain;      // beats still to issue
    logic                 r_infl;        // a read is in flight this cycle
    logic                 r_infl_last;   // ...and it is the final beat
    logic [WL_DATA-1:0]   r_fifo_data [2];
    logic [1:0]           r_fifo_last;
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_occ;
    logic                 r_done;

    logic                 w_cmd_hs;
    logic                 w_wr_hs;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_wr_last;
    logic                 w_rd_last_pop;
    logic [1:0]           w_slots_used;

    assign rd_valid      = (r_occ != 2'd0);
    assign rd_data       = r_fifo_data[r_rptr];
    assign rd_last       = rd_valid & r_fifo_last[r_rptr];
    assign mem_addr      = r_addr;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

    assign w_cmd_hs      = cmd_valid & cmd_ready;
    assign w_wr_hs       = wr_valid & wr_ready;
    assign w_pop         = rd_valid & rd_ready;
    assign w_wr_last     = w_wr_hs & (r_remain == ONE);
    assign w_rd_last_pop = w_pop & rd_last;

    // Occupancy after this cycle's pop plus the read still in flight; a new
    // read may issue only while that leaves a free FIFO slot.
    assign w_slots_used  = r_occ + {1'b0, r_infl} - {1'b0, w_pop};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state output drive
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        mem_ena     = 1'b0;
        mem_wdata   = '0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so the port reads 0 while reset is held and 1
                // as soon as it is released.
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    w_state_nxt = cmd_write ? WR : RD;
                end
            end
            WR: begin
                wr_ready  = 1'b1;
                mem_ena   = wr_valid;
                mem_wdata = wr_data;
                if (w_wr_last) begin
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                w_issue = (r_remain != '0) && (w_slots_used < 2'd2);
                if (w_rd_last_pop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address/beat counters, read pipeline, FIFO storage and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr         <= '0;
            r_remain       <= '0;
            r_infl         <= 1'b0;
            r_infl_last    <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_occ          <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_wr_last | w_rd_last_pop;

            if (w_cmd_hs) begin
                r_addr   <= cmd_addr;
                r_remain <= {1'b0, cmd_len} + ONE;
            end else if (w_wr_hs || w_issue) begin
                r_addr   <= r_addr + 1'b1;
                r_remain <= r_remain - ONE;
            end

            r_infl <= w_issue;
            if (w_issue) begin
                r_infl_last <= (r_remain == ONE);
            end

            // SRAM data for last cycle's address is valid now
            if (r_infl) begin
                r_fifo_data[r_wptr] <= mem_rdata;
                r_fifo_last[r_wptr] <= r_infl_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
        end
    end

endmodule
